// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V counters, pixel-request interface, built-in
// test patterns and a latency-matched output stage for hs/vs/de/rgb.
module vga_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VIDEO = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VIDEO = 480,
  parameter int V_FRONT = 10,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int PIX_LAT = 1,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [11:0]      solid_rgb,
  output logic             pix_req,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  input  logic [11:0]      pix_rgb,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             frame_start,
  output logic [3:0]       r,
  output logic [3:0]       g,
  output logic [3:0]       b
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VIDEO + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VIDEO + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  // pipeline word: {mode[17:16], frame_start[15], de[14], vs_raw[13], hs_raw[12], pattern[11:0]}
  localparam int SW = 18;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_OFS   = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_OFS   = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // one extra bit so a visible window ending exactly at 2**CNT_W still compares correctly
  localparam logic [CNT_W:0] H_SYNC_END = (CNT_W+1)'(H_SYNC);
  localparam logic [CNT_W:0] V_SYNC_END = (CNT_W+1)'(V_SYNC);
  localparam logic [CNT_W:0] H_VIS_LO   = (CNT_W+1)'(H_START);
  localparam logic [CNT_W:0] H_VIS_HI   = (CNT_W+1)'(H_START + H_VIDEO);
  localparam logic [CNT_W:0] V_VIS_LO   = (CNT_W+1)'(V_START);
  localparam logic [CNT_W:0] V_VIS_HI   = (CNT_W+1)'(V_START + V_VIDEO);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic [1:0]       mode_q;
  logic             hs_raw;
  logic             vs_raw;
  logic             h_vis;
  logic             v_vis;
  logic             at_origin;
  logic [CNT_W+2:0] x8;
  logic [2:0]       bar;
  logic [11:0]      pat;
  logic [SW-1:0]    stage0;
  logic [SW-1:0]    tap;
  logic [11:0]      rgb_next;

  // raster counters: vcnt steps only when hcnt wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_ONE;
    end else begin
      hcnt <= hcnt + CNT_ONE;
    end
  end

  // mode is only sampled at the frame origin so a frame never mixes sources
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 2'd0;
    end else if (at_origin) begin
      mode_q <= mode;
    end else begin
      mode_q <= mode_q;
    end
  end

  // sync, visibility and request coordinates straight from the counters
  always_comb begin
    at_origin = (hcnt == '0) && (vcnt == '0);
    hs_raw    = {1'b0, hcnt} < H_SYNC_END;
    vs_raw    = {1'b0, vcnt} < V_SYNC_END;
    h_vis     = ({1'b0, hcnt} >= H_VIS_LO) && ({1'b0, hcnt} < H_VIS_HI);
    v_vis     = ({1'b0, vcnt} >= V_VIS_LO) && ({1'b0, vcnt} < V_VIS_HI);
    pix_req   = h_vis && v_vis;
    if (pix_req) begin
      x = hcnt - H_OFS;
      y = vcnt - V_OFS;
    end else begin
      x = '0;
      y = '0;
    end
  end

  // bar index = number of thresholds k*H_VIDEO/8 that x has reached
  always_comb begin
    x8  = {x, 3'b000};
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      bar = bar + ((x8 >= (CNT_W+3)'(k * H_VIDEO)) ? 3'd1 : 3'd0);
    end
    case (mode_q)
      2'd1:    pat = solid_rgb;
      2'd2:    pat = bar_colour(bar);
      2'd3:    pat = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
      default: pat = 12'h000;
    endcase
    stage0 = {mode_q, at_origin, pix_req, vs_raw, hs_raw, pat};
  end

  if (PIX_LAT == 0) begin : g_nolat
    assign tap = stage0;
  end else begin : g_lat
    logic [SW-1:0] dly [PIX_LAT];

    // delay line matching the upstream source latency
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIX_LAT; i++) dly[i] <= '0;
      end else begin
        dly[0] <= stage0;
        for (int i = 1; i < PIX_LAT; i++) dly[i] <= dly[i-1];
      end
    end
    assign tap = dly[PIX_LAT-1];
  end

  // blanking always forces black; external mode takes the source colour arriving now
  always_comb begin
    if (!tap[14]) begin
      rgb_next = 12'h000;
    end else if (tap[17:16] == 2'd0) begin
      rgb_next = pix_rgb;
    end else begin
      rgb_next = tap[11:0];
    end
  end

  // output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      hs          <= ~HS_ACT;
      vs          <= ~VS_ACT;
      de          <= 1'b0;
      frame_start <= 1'b0;
      r           <= 4'h0;
      g           <= 4'h0;
      b           <= 4'h0;
    end else begin
      hs          <= tap[12] ? HS_ACT : ~HS_ACT;
      vs          <= tap[13] ? VS_ACT : ~VS_ACT;
      de          <= tap[14];
      frame_start <= tap[15];
      r           <= rgb_next[11:8];
      g           <= rgb_next[7:4];
      b           <= rgb_next[3:0];
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small raster (16x8, PIX_LAT=1) plus a
// default 640x480 instance with positive sync polarity.
module tb_vga_timing_gen;

  localparam logic [15:0] CLR = {1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;
  logic [11:0] pix_rgb;
  logic        pix_req;
  logic [4:0]  x;
  logic [4:0]  y;
  logic        hs, vs, de, frame_start;
  logic [3:0]  r, g, b;

  logic [1:0]  mode2;
  logic [11:0] solid2;
  logic [11:0] pix_rgb2;
  logic        pix_req2;
  logic [9:0]  x2;
  logic [9:0]  y2;
  logic        hs2, vs2, de2, fs2;
  logic [3:0]  r2, g2, b2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bh = 0;
  int bv = 0;
  logic [1:0]  bm = 2'd0;
  logic [15:0] d1 = CLR;
  logic [15:0] d2 = CLR;
  logic        chk_en = 1'b0;
  int hs_low, vs_low, de_cnt, fs_cnt, fs_first, fs_second;
  int hs2_r1, hs2_r2, hs2_f1, vs2_r1, vs2_f1;
  logic hs2_prev, vs2_prev;

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(2), .H_VIDEO(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(1), .V_VIDEO(4), .V_FRONT(1),
    .HS_POL(0), .VS_POL(0), .PIX_LAT(1), .CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .pix_req(pix_req), .x(x), .y(y), .pix_rgb(pix_rgb),
    .hs(hs), .vs(vs), .de(de), .frame_start(frame_start),
    .r(r), .g(g), .b(b)
  );

  vga_timing_gen #(.HS_POL(1), .VS_POL(1)) dut2 (
    .clk(clk), .rst(rst), .mode(mode2), .solid_rgb(solid2),
    .pix_req(pix_req2), .x(x2), .y(y2), .pix_rgb(pix_rgb2),
    .hs(hs2), .vs(vs2), .de(de2), .frame_start(fs2),
    .r(r2), .g(g2), .b(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_stats();
    hs_low = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
    hs2_r1 = -1; hs2_r2 = -1; hs2_f1 = -1; vs2_r1 = -1; vs2_f1 = -1;
    hs2_prev = 1'b0; vs2_prev = 1'b0;
  endtask

  // one pixel clock: check request, advance model, check delayed outputs
  task automatic tick();
    logic        vis;
    logic [4:0]  ex, ey;
    logic [11:0] col, src;
    logic [15:0] e;
    vis = (bh >= 6) && (bh < 14) && (bv >= 3) && (bv < 7);
    ex  = vis ? 5'(bh - 6) : 5'd0;
    ey  = vis ? 5'(bv - 3) : 5'd0;
    if (chk_en) check("pix_req/x/y", {21'd0, pix_req, x, y}, {21'd0, vis, ex, ey});
    if (bh == 0 && bv == 0) bm = mode;
    case (bm)
      2'd0:    col = {ex[3:0], ey[3:0], 4'h5};
      2'd1:    col = solid_rgb;
      2'd2:    col = BARS[ex[2:0]];
      default: col = (ex[3] ^ ey[3]) ? 12'hFFF : 12'h000;
    endcase
    e   = {bh >= 4, bv >= 2, vis, (bh == 0 && bv == 0), vis ? col : 12'h000};
    src = vis ? {ex[3:0], ey[3:0], 4'h5} : 12'hEEE;
    @(posedge clk);
    if (rst) begin
      d1 = CLR; d2 = CLR; bh = 0; bv = 0; bm = 2'd0;
      clear_stats();
    end else begin
      d2 = d1;
      d1 = e;
      if (bh == 15) begin
        bh = 0;
        bv = (bv == 7) ? 0 : bv + 1;
      end else begin
        bh++;
      end
    end
    #1;
    cyc++;
    pix_rgb = src;
    if (chk_en) check("outputs", {16'd0, hs, vs, de, frame_start, r, g, b}, {16'd0, d2});
    if (!hs) hs_low++;
    if (!vs) vs_low++;
    if (de) de_cnt++;
    if (frame_start) begin
      fs_cnt++;
      if (fs_first < 0) fs_first = cyc;
      else if (fs_second < 0) fs_second = cyc;
    end
    if (hs2 && !hs2_prev) begin
      if (hs2_r1 < 0) hs2_r1 = cyc;
      else if (hs2_r2 < 0) hs2_r2 = cyc;
    end
    if (!hs2 && hs2_prev && hs2_f1 < 0) hs2_f1 = cyc;
    if (vs2 && !vs2_prev && vs2_r1 < 0) vs2_r1 = cyc;
    if (!vs2 && vs2_prev && vs2_f1 < 0) vs2_f1 = cyc;
    hs2_prev = hs2;
    vs2_prev = vs2;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; solid_rgb = 12'h000; pix_rgb = 12'h000;
    mode2 = 2'd0; solid2 = 12'h000; pix_rgb2 = 12'h000;
    clear_stats();
    repeat (3) tick();
    chk_en = 1'b1;
    rst = 1'b0;
    cyc = 0;

    // reset state
    check("rst_hs_vs_de_fs", {28'd0, hs, vs, de, frame_start}, 32'hC);
    check("rst_rgb", {20'd0, r, g, b}, 32'h0);
    check("rst_dut2_hs_vs", {30'd0, hs2, vs2}, 32'h0);

    // external mode, timing counts over two frames
    run_to(2);
    check("first_frame_start", {31'd0, frame_start}, 32'd1);
    run_to(53);
    check("pix_req_before_vis", {31'd0, pix_req}, 32'd0);
    run_to(54);
    check("pix_req_first", {21'd0, pix_req, x, y}, {21'd0, 1'b1, 5'd0, 5'd0});
    run_to(56);
    check("ext_rgb_first", {19'd0, de, r, g, b}, {19'd0, 1'b1, 12'h005});
    run_to(111);
    check("ext_rgb_last", {19'd0, de, r, g, b}, {19'd0, 1'b1, 12'h735});
    run_to(112);
    check("blank_after_line", {19'd0, de, r, g, b}, 32'd0);
    run_to(257);
    check("hs_low_count", hs_low, 32'd64);
    check("vs_low_count", vs_low, 32'd64);
    check("de_count", de_cnt, 32'd64);
    check("fs_count", fs_cnt, 32'd2);
    check("fs_first", fs_first, 32'd2);
    check("fs_period", fs_second, 32'd130);

    // solid colour, then mid-frame switch to bars
    mode = 2'd1; solid_rgb = 12'hA5C;
    run_to(440);
    check("solid_first", {19'd0, de, r, g, b}, {19'd0, 1'b1, 12'hA5C});
    run_to(454);
    mode = 2'd2;
    run_to(474);
    check("solid_holds", {19'd0, de, r, g, b}, {19'd0, 1'b1, 12'hA5C});
    run_to(514);
    check("fs_frame4", {31'd0, frame_start}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      run_to(568 + i);
      check("bar_colour", {19'd0, de, r, g, b}, {19'd0, 1'b1, BARS[i]});
    end
    run_to(600);
    mode = 2'd3;
    run_to(696);
    check("checker_origin", {19'd0, de, r, g, b}, {19'd0, 1'b1, 12'h000});

    // mid-frame reset at hcnt=9, vcnt=4
    run_to(841);
    check("pre_reset_pos", {21'd0, pix_req, x, y}, {21'd0, 1'b1, 5'd3, 5'd1});
    rst = 1'b1;
    tick();
    check("midrst_hs_vs_de_fs", {28'd0, hs, vs, de, frame_start}, 32'hC);
    check("midrst_rgb", {20'd0, r, g, b}, 32'h0);
    check("midrst_counter", {21'd0, pix_req, x, y}, 32'd0);
    rst = 1'b0;
    mode = 2'd0;
    cyc = 0;
    run_to(2);
    check("restart_fs", fs_first, 32'd2);
    run_to(56);
    check("restart_ext_rgb", {19'd0, de, r, g, b}, {19'd0, 1'b1, 12'h005});

    // default 640x480 timing with positive polarity
    run_to(1700);
    check("dut2_hs_rise", hs2_r1, 32'd2);
    check("dut2_hs_width", hs2_f1 - hs2_r1, 32'd96);
    check("dut2_line_len", hs2_r2 - hs2_r1, 32'd800);
    check("dut2_vs_rise", vs2_r1, 32'd2);
    check("dut2_vs_width", vs2_f1 - vs2_r1, 32'd1600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
